multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle MIPS datapath. It initiates every ALU operation and drives aluCtr, the operand selects and all datapath write enables.
- Decodes op/funct from the instruction register and sequences fetch, decode, execute, memory and writeback, with one stall handshake toward memory.
- Counts retired instructions and flags unsupported opcodes.

---
 rtl/mips_ctrl_pkg.sv | 42 ++++
 rtl/mips_alu_dec.sv | 27 ++
 rtl/multicycle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcode/funct fields and ALU operation codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ      = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BAD = 4'b1111;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation code and flags
// whether the funct is one the datapath supports.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluCtr,
  output logic       valid
);

  always_comb begin
    valid = 1'b1;
    unique case (funct)
      FN_ADD:  aluCtr = ALU_ADD;
      FN_SUB:  aluCtr = ALU_SUB;
      FN_AND:  aluCtr = ALU_AND;
      FN_OR:   aluCtr = ALU_OR;
      FN_NOR:  aluCtr = ALU_NOR;
      FN_SLT:  aluCtr = ALU_SLT;
      default: begin
        aluCtr = ALU_BAD;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences each
// instruction, counts retirements and flags unsupported opcodes.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             memReady,
  output logic [3:0]       aluCtr,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       pcSource,
  output logic             pcEn,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regDst,
  output logic             memToReg,
  output logic             regWrite,
  output logic             instrDone,
  output logic [CNT_W-1:0] instret,
  output logic             illegalOp
);

  state_t     state, state_next;
  logic [3:0] rtype_ctr;
  logic       rtype_valid;
  logic       set_illegal;

  mips_alu_dec u_alu_dec (
    .funct  (funct),
    .aluCtr (rtype_ctr),
    .valid  (rtype_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      instret   <= '0;
      illegalOp <= 1'b0;
    end else begin
      state <= state_next;
      if (instrDone)   instret   <= instret + CNT_W'(1);
      if (set_illegal) illegalOp <= 1'b1;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    aluCtr      = 4'b0000;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSource    = 2'b00;
    pcEn        = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    instrDone   = 1'b0;

    case (state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        aluCtr  = ALU_ADD;
        irWrite = memReady;
        pcEn    = memReady;
        if (memReady) state_next = DECODE;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        aluCtr  = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPE_EX;
          OP_BEQ:       state_next = BEQ;
          OP_J:         state_next = JUMP;
          OP_ADDI:      state_next = ADDI_EX;
          default: begin
            // Unsupported opcodes are retired as no-ops so the PC keeps moving.
            state_next  = FETCH;
            set_illegal = 1'b1;
            instrDone   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        aluCtr     = ALU_ADD;
        state_next = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) state_next = MEMWB;
      end
      MEMWB: begin
        regWrite   = 1'b1;
        memToReg   = 1'b1;
        instrDone  = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memReady) begin
          instrDone  = 1'b1;
          state_next = FETCH;
        end
      end
      RTYPE_EX: begin
        aluSrcA    = 1'b1;
        aluCtr     = rtype_ctr;
        state_next = RTYPE_WB;
      end
      RTYPE_WB: begin
        regDst     = 1'b1;
        regWrite   = rtype_valid;
        instrDone  = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        aluSrcA    = 1'b1;
        aluCtr     = ALU_SUB;
        pcSource   = 2'b01;
        pcEn       = zero;
        instrDone  = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        pcSource   = 2'b10;
        pcEn       = 1'b1;
        instrDone  = 1'b1;
        state_next = FETCH;
      end
      ADDI_EX: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        aluCtr     = ALU_ADD;
        state_next = ADDI_WB;
      end
      ADDI_WB: begin
        regWrite   = 1'b1;
        instrDone  = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction table,
// randomized instruction stream against an instruction-level model, and
// hand-written reset/wrap sequences.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [3:0] alu_ctr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
  } ctl_t;

  typedef struct packed {
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             rdy;
    ctl_t             exp;
    logic [CNT_W-1:0] cnt;
    logic             ill;
  } vec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         fetch_wait;
    int         mem_wait;
  } instr_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op, funct;
  logic             zero, memReady;
  logic [3:0]       aluCtr;
  logic             aluSrcA;
  logic [1:0]       aluSrcB, pcSource;
  logic             pcEn, iorD, memRead, memWrite, irWrite;
  logic             regDst, memToReg, regWrite, instrDone;
  logic [CNT_W-1:0] instret;
  logic             illegalOp;

  ctl_t act;
  assign act = {aluCtr, aluSrcA, aluSrcB, pcSource, pcEn, iorD, memRead,
                memWrite, irWrite, regDst, memToReg, regWrite, instrDone};

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memReady(memReady), .aluCtr(aluCtr), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSource(pcSource), .pcEn(pcEn), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
    .instrDone(instrDone), .instret(instret), .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_bad = 0;
  vec_t             plan[$];
  logic [CNT_W-1:0] m_cnt;
  logic             m_ill;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected control words, one per step of an instruction.
  function automatic ctl_t c_fetch(logic rdy);
    ctl_t c = '0;
    c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_ctr = 4'b0010;
    c.ir_write = rdy; c.pc_en = rdy;
    return c;
  endfunction
  function automatic ctl_t c_decode(logic bad_op);
    ctl_t c = '0;
    c.alu_src_b = 2'b11; c.alu_ctr = 4'b0010; c.instr_done = bad_op;
    return c;
  endfunction
  function automatic ctl_t c_addr_calc();
    ctl_t c = '0;
    c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctr = 4'b0010;
    return c;
  endfunction
  function automatic ctl_t c_mem(logic wr, logic rdy);
    ctl_t c = '0;
    c.ior_d = 1; c.mem_read = !wr; c.mem_write = wr; c.instr_done = wr & rdy;
    return c;
  endfunction
  function automatic ctl_t c_wb(logic from_mem, logic rd, logic wen);
    ctl_t c = '0;
    c.mem_to_reg = from_mem; c.reg_dst = rd; c.reg_write = wen;
    c.instr_done = 1;
    return c;
  endfunction

  // Returns {valid, code} for an R-type funct.
  function automatic logic [4:0] alu_of(logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 4'b0010};
      6'b100010: return {1'b1, 4'b0110};
      6'b100100: return {1'b1, 4'b0000};
      6'b100101: return {1'b1, 4'b0001};
      6'b100111: return {1'b1, 4'b1100};
      6'b101010: return {1'b1, 4'b0111};
      default:   return {1'b0, 4'b1111};
    endcase
  endfunction

  function automatic void push(logic [5:0] o, logic [5:0] f, logic z,
                               logic rdy, ctl_t e);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.rdy = rdy; v.exp = e;
    v.cnt = m_cnt; v.ill = m_ill;
    plan.push_back(v);
    if (e.instr_done) m_cnt = m_cnt + 1'b1;
  endfunction

  // Expands one instruction into per-cycle stimulus and expected outputs.
  // Inputs that should be ignored in a step are randomized.
  function automatic void add_instr(instr_t in);
    logic [5:0] o = in.op;
    logic [5:0] f = in.funct;
    logic [4:0] a = alu_of(in.funct);
    ctl_t       c;
    logic       bad = !(o inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08});
    for (int i = 0; i < in.fetch_wait; i++)
      push(o, f, 1'($urandom), 1'b0, c_fetch(1'b0));
    push(o, f, 1'($urandom), 1'b1, c_fetch(1'b1));
    push(o, f, 1'($urandom), 1'($urandom), c_decode(bad));
    if (bad) begin
      m_ill = 1'b1;
      return;
    end
    case (o)
      6'h23, 6'h2b: begin
        push(o, f, 1'($urandom), 1'($urandom), c_addr_calc());
        for (int i = 0; i < in.mem_wait; i++)
          push(o, f, 1'($urandom), 1'b0, c_mem(o == 6'h2b, 1'b0));
        push(o, f, 1'($urandom), 1'b1, c_mem(o == 6'h2b, 1'b1));
        if (o == 6'h23)
          push(o, f, 1'($urandom), 1'($urandom), c_wb(1'b1, 1'b0, 1'b1));
      end
      6'h00: begin
        c = '0; c.alu_src_a = 1; c.alu_ctr = a[3:0];
        push(o, f, 1'($urandom), 1'($urandom), c);
        push(o, f, 1'($urandom), 1'($urandom), c_wb(1'b0, 1'b1, a[4]));
      end
      6'h04: begin
        c = '0; c.alu_src_a = 1; c.alu_ctr = 4'b0110; c.pc_source = 2'b01;
        c.pc_en = in.zero; c.instr_done = 1;
        push(o, f, in.zero, 1'($urandom), c);
      end
      6'h02: begin
        c = '0; c.pc_source = 2'b10; c.pc_en = 1; c.instr_done = 1;
        push(o, f, 1'($urandom), 1'($urandom), c);
      end
      default: begin
        push(o, f, 1'($urandom), 1'($urandom), c_addr_calc());
        push(o, f, 1'($urandom), 1'($urandom), c_wb(1'b0, 1'b0, 1'b1));
      end
    endcase
  endfunction

  task automatic apply(input vec_t v);
    op = v.op; funct = v.funct; zero = v.zero; memReady = v.rdy;
    @(negedge clk);
    check("ctl", 32'(act), 32'(v.exp));
    check("instret", 32'(instret), 32'(v.cnt));
    check("illegalOp", 32'(illegalOp), 32'(v.ill));
    @(posedge clk);
    #1;
  endtask

  task automatic run_plan(input int limit);
    int n = 0;
    while (plan.size() > 0 && n < limit) begin
      apply(plan.pop_front());
      n++;
    end
    plan.delete();
  endtask

  instr_t dir[10];
  instr_t r;

  initial begin
    dir = '{
      '{6'h00, 6'b100000, 1'b0, 0, 0},  // add
      '{6'h23, 6'b000000, 1'b0, 0, 3},  // lw, 3 stall cycles in MEMRD
      '{6'h04, 6'b000000, 1'b1, 2, 0},  // beq taken after a 2-cycle fetch stall
      '{6'h04, 6'b000000, 1'b0, 0, 0},  // beq not taken
      '{6'h3f, 6'b000000, 1'b0, 0, 0},  // unsupported opcode
      '{6'h08, 6'b000000, 1'b0, 1, 0},  // addi
      '{6'h00, 6'b000001, 1'b0, 0, 0},  // bad funct: no write, retires
      '{6'h2b, 6'b000000, 1'b0, 0, 2},  // sw with stalls
      '{6'h02, 6'b000000, 1'b0, 0, 0},  // j
      '{6'h00, 6'b101010, 1'b0, 0, 0}   // slt
    };

    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; memReady = 1'b0;
    m_cnt = '0; m_ill = 1'b0;
    @(negedge clk);
    check("reset_ctl", 32'(act), 32'(c_fetch(1'b0)));
    check("reset_instret", 32'(instret), 32'd0);
    check("reset_illegal", 32'(illegalOp), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (dir[i]) add_instr(dir[i]);
    run_plan(1 << 30);

    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 6))
        0: r.op = 6'h23;
        1: r.op = 6'h2b;
        2: r.op = 6'h00;
        3: r.op = 6'h04;
        4: r.op = 6'h02;
        5: r.op = 6'h08;
        default: begin
          do r.op = 6'($urandom);
          while (r.op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08});
        end
      endcase
      if ($urandom_range(0, 4) == 0) r.funct = 6'($urandom);
      else begin
        case ($urandom_range(0, 5))
          0: r.funct = 6'b100000;
          1: r.funct = 6'b100010;
          2: r.funct = 6'b100100;
          3: r.funct = 6'b100101;
          4: r.funct = 6'b100111;
          default: r.funct = 6'b101010;
        endcase
      end
      r.zero = 1'($urandom);
      r.fetch_wait = $urandom_range(0, 2);
      r.mem_wait = $urandom_range(0, 2);
      add_instr(r);
      run_plan(1 << 30);
    end

    // Reset in the middle of a stalled store must act before the next edge.
    add_instr('{6'h00, 6'b100000, 1'b0, 0, 0});
    add_instr('{6'h2b, 6'b000000, 1'b0, 0, 5});
    run_plan(8);
    memReady = 1'b0;
    @(negedge clk);
    check("memwr_before_reset", 32'(memWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ctl", 32'(act), 32'(c_fetch(1'b0)));
    check("async_reset_instret", 32'(instret), 32'd0);
    check("async_reset_illegal", 32'(illegalOp), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_cnt = '0; m_ill = 1'b0;

    // Sixteen jumps wrap a 4-bit counter back to zero.
    for (int k = 0; k < 16; k++) add_instr('{6'h02, 6'h00, 1'b0, 0, 0});
    run_plan(1 << 30);
    memReady = 1'b0;
    @(negedge clk);
    check("instret_wrap", 32'(instret), 32'(m_cnt));
    check("instret_wrap_zero", 32'(instret), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
